// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: shared widths, FSM state and result-queue entry type for the writeback arbiter
package writeback_arbiter_pkg;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {IDLE, PEND, FORCE} wb_state_e;
   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/writeback_arbiter_fifo.sv
// wb_result_fifo: DEPTH-entry queue of long-latency {rd, data} results with occupancy count
module wb_result_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  wb_entry_t                    din,
   output wb_entry_t                    head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   logic [PW-1:0] wptr, rptr;
   wb_entry_t     mem [DEPTH];
   assign head  = mem[rptr];
   assign empty = count == '0;
   // pointers wrap modulo DEPTH so non-power-of-two depths work
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
         if (pop) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   // storage needs no reset; stale entries are unreachable once the pointers clear
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= din;
   end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the register-file write port between the W stage and queued mul/div results
// Optional same-cycle bypass of long-latency results enabled by defining WB_ARB_BYPASS_EN
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_regwrite,
   input  logic [REG_W-1:0]  pipe_rd,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              lu_valid,
   output logic              lu_ready,
   input  logic [REG_W-1:0]  lu_rd,
   input  logic [DATA_W-1:0] lu_data,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_rd,
   output logic [DATA_W-1:0] rf_wd,
   output logic              stall_pipe
);
   localparam int CW = $clog2(DEPTH + 1);
   wb_state_e       state, state_n;
   logic [3:0]      starve, starve_n;
   logic [CW-1:0]   count;
   logic            empty, push, pop, acc, pipe_ok, byp, drained;
   wb_entry_t       head;
   assign lu_ready = count < CW'(DEPTH);
   assign acc      = lu_valid & lu_ready;
   assign pipe_ok  = pipe_regwrite & (pipe_rd != '0);
   assign push     = acc & (lu_rd != '0) & !byp;
   assign drained  = pop & !push & (count == CW'(1));
   wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   ('{rd: lu_rd, data: lu_data}),
      .head  (head),
      .count (count),
      .empty (empty)
   );
   // state and starvation counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         starve <= '0;
      end else begin
         state  <= state_n;
         starve <= starve_n;
      end
   end
   // next state: count lost arbitration cycles while pending, force a drain at the limit
   always_comb begin
      starve_n = (state == PEND && !pop) ? ((starve == 4'(STARVE_MAX)) ? starve : starve + 4'd1) : '0;
      state_n  = IDLE;
      case (state)
         IDLE:    state_n = push ? PEND : IDLE;
         PEND:    state_n = pop ? (drained ? IDLE : PEND) : ((starve_n == 4'(STARVE_MAX)) ? FORCE : PEND);
         FORCE:   state_n = drained ? IDLE : PEND;
         default: state_n = IDLE;
      endcase
   end
   // outputs: forced drain beats the pipe, the pipe beats a pending queue head
   always_comb begin
      stall_pipe = state == FORCE;
      pop        = !empty & (stall_pipe | !pipe_ok);
      byp        = 1'b0;
`ifdef WB_ARB_BYPASS_EN
      byp        = !stall_pipe & !pipe_ok & empty & acc & (lu_rd != '0);
`endif
      rf_we      = pop | pipe_ok | byp;
      rf_rd      = pop ? head.rd   : pipe_ok ? pipe_rd   : byp ? lu_rd   : '0;
      rf_wd      = pop ? head.data : pipe_ok ? pipe_data : byp ? lu_data : '0;
   end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and random checks of writeback_arbiter against a queue-based model
module tb_writeback_arbiter;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;
`ifdef WB_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   typedef struct packed {logic [4:0] rd; logic [31:0] d;} ent_t;

   logic        clk = 0, rst_n = 0;
   logic        pipe_regwrite = 0, lu_valid = 0;
   logic [4:0]  pipe_rd = 0, lu_rd = 0;
   logic [31:0] pipe_data = 0, lu_data = 0;
   logic        lu_ready, rf_we, stall_pipe;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wd;

   int   vectors = 0, miscompares = 0;
   ent_t q[$];
   int   waited = 0;
   bit   fz = 0;
   logic        obs_we, obs_stall, obs_ready;
   logic [4:0]  obs_rd;
   logic [31:0] obs_wd;

   writeback_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_regwrite(pipe_regwrite), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .stall_pipe(stall_pipe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock cycle: drive, compare against the model, then advance the model at the edge
   task automatic cyc(input bit pw, input logic [4:0] prd, input logic [31:0] pd,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
      bit ne, e_ready, acc, pok, pop, byp, e_we;
      logic [4:0]  e_rd;
      logic [31:0] e_wd;
      @(negedge clk);
      pipe_regwrite = pw; pipe_rd = prd; pipe_data = pd;
      lu_valid = lv; lu_rd = lrd; lu_data = ld;
      #1;
      ne      = q.size() > 0;
      e_ready = q.size() < DEPTH;
      acc     = lv && e_ready;
      pok     = pw && prd != 0;
      pop     = ne && (fz || !pok);
      byp     = BYP && !ne && !pok && acc && lrd != 0;
      e_we    = pop || pok || byp;
      e_rd    = pop ? q[0].rd : pok ? prd : byp ? lrd : 5'd0;
      e_wd    = pop ? q[0].d  : pok ? pd  : byp ? ld  : 32'd0;
      obs_we = rf_we; obs_rd = rf_rd; obs_wd = rf_wd; obs_stall = stall_pipe; obs_ready = lu_ready;
      chk("rf_we", 64'(rf_we), 64'(e_we));
      chk("rf_rd", 64'(rf_rd), 64'(e_rd));
      chk("rf_wd", 64'(rf_wd), 64'(e_wd));
      chk("stall_pipe", 64'(stall_pipe), 64'(fz));
      chk("lu_ready", 64'(lu_ready), 64'(e_ready));
      chk("count", 64'(dut.count), 64'(q.size()));
      @(posedge clk);
      if (pop) begin
         void'(q.pop_front());
         waited = 0;
      end else if (ne) waited++;
      if (acc && lrd != 0 && !byp) q.push_back('{rd: lrd, d: ld});
      fz = !fz && ne && !pop && waited >= STARVE_MAX;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      pipe_regwrite = 0; lu_valid = 0;
      #1;
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_stall", 64'(stall_pipe), 64'd0);
      chk("rst_ready", 64'(lu_ready), 64'd1);
      q.delete(); waited = 0; fz = 0;
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      logic [4:0]  a_rd;
      logic        a_we;
      int          n;
      #1;
      chk("por_rf_we", 64'(rf_we), 64'd0);
      chk("por_ready", 64'(lu_ready), 64'd1);
      chk("por_stall", 64'(stall_pipe), 64'd0);
      do_reset();

      // single long-latency result, idle pipe
      cyc(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
      a_we = obs_we; a_rd = obs_rd;
      idle();
      chk("req029_we", 64'(BYP ? a_we : obs_we), 64'd1);
      chk("req029_rd", 64'(BYP ? a_rd : obs_rd), 64'd5);
      idle();

      // busy pipe starves one queued result until a forced drain
      do_reset();
      cyc(1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 5'd3, 32'h33, 0, 0, 0);
         chk("req030_pipe_rd", 64'(obs_rd), 64'd3);
      end
      cyc(1, 5'd3, 32'h33, 0, 0, 0);
      chk("req030_stall", 64'(obs_stall), 64'd1);
      chk("req030_rd", 64'(obs_rd), 64'd7);
      idle();

      // queue fills, third result held until a pop frees space
      do_reset();
      cyc(1, 5'd3, 32'h1, 1, 5'd9, 32'h9);
      cyc(1, 5'd3, 32'h2, 1, 5'd10, 32'hA);
      cyc(1, 5'd3, 32'h3, 1, 5'd11, 32'hB);
      chk("req031_full", 64'(obs_ready), 64'd0);
      n = 0;
      while (!obs_ready && n < 20) begin
         cyc(1, 5'd3, 32'h4, 1, 5'd11, 32'hB);
         n++;
      end
      chk("req031_ready", 64'(obs_ready), 64'd1);
      repeat (12) idle();

      // rd 0 results are accepted and dropped
      do_reset();
      cyc(0, 0, 0, 1, 5'd0, 32'h1234);
      chk("req032_ready", 64'(obs_ready), 64'd1);
      chk("req032_we0", 64'(obs_we), 64'd0);
      repeat (3) begin
         idle();
         chk("req032_we", 64'(obs_we), 64'd0);
      end

      // asynchronous reset in the middle of a forced drain
      do_reset();
      cyc(1, 5'd3, 32'h1, 1, 5'd12, 32'hC);
      cyc(1, 5'd3, 32'h2, 1, 5'd13, 32'hD);
      n = 0;
      while (!fz && n < 20) begin
         cyc(1, 5'd3, 32'h5, 0, 0, 0);
         n++;
      end
      @(negedge clk);
      #1;
      chk("req033_in_force", 64'(stall_pipe), 64'd1);
      chk("req033_count2", 64'(dut.count), 64'd2);
      rst_n = 0;
      #1;
      chk("req033_stall", 64'(stall_pipe), 64'd0);
      chk("req033_count", 64'(dut.count), 64'd0);
      chk("req033_ready", 64'(lu_ready), 64'd1);
      q.delete(); waited = 0; fz = 0;
      @(negedge clk);
      rst_n = 1;

      // random traffic, heavy then light pipe load
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 9) < ((i < 300) ? 8 : 3),
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom,
             $urandom_range(0, 2) != 0,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom);
      end
      repeat (10) idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
